// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state codes, grant
// encoding and the DMA alignment test.
package data_mem_arbiter_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] CPU       = 2'd1;
  localparam logic [1:0] DMA_BURST = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } gnt_e;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the MEM stage, the DMA engine, the data memory and the
// arbiter; the arbiter takes the slave side, clients and memory the master side.
interface data_mem_arbiter_if #(
  parameter int CNT_W = 4
);
  import data_mem_arbiter_pkg::*;

  // Handshakes: cpu_req is answered in the same cycle (cpu_stall=0 means the
  // access happened); dma_req is held until the one-cycle dma_ack pulse that
  // follows its grant, after which the DMA drops it or presents the next beat.
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic        dma_lock;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_burst_cnt;
  logic [CNT_W-1:0] dbg_starve_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_ack, dma_rdata, dma_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output dbg_state, dbg_burst_cnt, dbg_starve_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata, dma_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  dbg_state, dbg_burst_cnt, dbg_starve_cnt
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (priority)
// and a DMA port with starvation protection and lockable bursts.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  data_mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             dma_ack_q, dma_ack_d;
  logic             dma_err_q, dma_err_d;
  logic [31:0]      dma_rdata_q, dma_rdata_d;

  gnt_e gnt;
  logic burst_cont;
  logic dma_req_eff;
  logic dma_bad_addr;

  // A locked burst assumes the DMA presents its next beat in the ack cycle,
  // so continuation bypasses the ack-cycle masking that guards plain requests.
  assign burst_cont   = (state_q == DMA_BURST) && bus.dma_req && bus.dma_lock &&
                        (burst_cnt_q < BURST_LIM);
  assign dma_req_eff  = bus.dma_req && !dma_ack_q;
  assign dma_bad_addr = is_misaligned(bus.dma_addr[1:0]);

  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      gnt = GNT_NONE;
    end else if (burst_cont) begin
      gnt = GNT_DMA;
    end else if (dma_req_eff && (!bus.cpu_req || starve_cnt_q == STARVE_MAX)) begin
      gnt = GNT_DMA;
    end else if (bus.cpu_req) begin
      gnt = GNT_CPU;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (gnt)
      GNT_DMA: state_d = DMA_BURST;
      GNT_CPU: state_d = CPU;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    burst_cnt_d = '0;
    if (gnt == GNT_DMA) begin
      burst_cnt_d = (burst_cnt_q == BURST_LIM) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
    end
  end

  // Counts on the raw request so the ack cycle still counts as a CPU win
  // while the DMA keeps asking.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gnt == GNT_DMA || !bus.dma_req) begin
      starve_cnt_d = '0;
    end else if (gnt == GNT_CPU && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.cpu_rdata = '0;
    case (gnt)
      GNT_CPU: begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_read  = !bus.cpu_we;
        bus.mem_write = bus.cpu_we;
        bus.cpu_rdata = bus.cpu_we ? 32'd0 : bus.mem_rdata;
      end
      GNT_DMA: begin
        bus.mem_addr  = bus.dma_addr;
        bus.mem_wdata = bus.dma_wdata;
        bus.mem_read  = !bus.dma_we;
        bus.mem_write = bus.dma_we && !dma_bad_addr;
      end
      default: ;
    endcase
  end

  // dma_rdata only reloads on DMA reads; writes leave the last read value.
  always_comb begin
    dma_ack_d   = (gnt == GNT_DMA);
    dma_err_d   = (gnt == GNT_DMA) && dma_bad_addr;
    dma_rdata_d = dma_rdata_q;
    if (gnt == GNT_DMA && !bus.dma_we) begin
      dma_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      starve_cnt_q <= '0;
      dma_ack_q    <= 1'b0;
      dma_err_q    <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      dma_ack_q    <= dma_ack_d;
      dma_err_q    <= dma_err_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign bus.cpu_stall      = bus.cpu_req && (gnt != GNT_CPU);
  assign bus.dma_ack        = dma_ack_q;
  assign bus.dma_err        = dma_err_q;
  assign bus.dma_rdata      = dma_rdata_q;
  assign bus.dbg_state      = state_q;
  assign bus.dbg_burst_cnt  = burst_cnt_q;
  assign bus.dbg_starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter with a combinational-read memory
// model and an expected-data queue for CPU and DMA read results.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [0:63];
  logic [31:0] exp_v;

  data_mem_arbiter_if #(.CNT_W(4)) bus();

  data_mem_arbiter #(.STARVE_LIMIT(4), .BURST_MAX(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_write) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_lock  = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
  endtask

  task automatic cpu_write(input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = data;
    next_cycle();
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h40; bus.cpu_wdata = 32'h55;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h44; bus.dma_wdata = 32'h66;
    settle();
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write: got %0b exp 0", bus.mem_write); end
    checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %0b exp 0", bus.mem_read); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %0h exp 0", bus.mem_addr); end
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_cpu_stall: got %0b exp 1", bus.cpu_stall); end
    checks++; if (bus.dma_ack !== 1'b0 || bus.dma_err !== 1'b0) begin errors++; $display("FAIL reset_dma_ack_err: got %0b/%0b exp 0/0", bus.dma_ack, bus.dma_err); end
    checks++; if (bus.dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata: got %0h exp 0", bus.dma_rdata); end
    checks++; if (bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", bus.dbg_state, IDLE); end
    next_cycle();
    settle();
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL reset_no_write: got %0d writes exp 0", wr_cnt); end
    idle_inputs();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_cpu_only();
    int w0;
    w0 = wr_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    settle();
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %0b exp 0", bus.cpu_stall); end
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_addr !== 32'h10) begin errors++; $display("FAIL cpu_wr_mem: got we=%0b addr=%0h exp 1/10", bus.mem_write, bus.mem_addr); end
    next_cycle();
    bus.cpu_we = 1'b0;
    settle();
    checks++; if (bus.cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_rd_stall: got %0b exp 0", bus.cpu_stall); end
    exp_v = exp_q.pop_front();
    checks++; if (bus.cpu_rdata !== exp_v) begin errors++; $display("FAIL cpu_rd_data: got %0h exp %0h", bus.cpu_rdata, exp_v); end
    next_cycle();
    bus.cpu_req = 1'b0;
    settle();
    checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL cpu_rdata_idle: got %0h exp 0", bus.cpu_rdata); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL cpu_write_pulses: got %0d exp 1", wr_cnt - w0); end
    next_cycle();
  endtask

  task automatic test_dma_only();
    cpu_write(32'h0, 32'h6C);
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b0; bus.dma_addr = 32'h0;
    exp_q.push_back(32'h6C);
    settle();
    checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL dma_rd_grant: got rd=%0b addr=%0h exp 1/0", bus.mem_read, bus.mem_addr); end
    checks++; if (bus.dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_early: got %0b exp 0", bus.dma_ack); end
    next_cycle();
    bus.dma_req = 1'b0;
    settle();
    checks++; if (bus.dma_ack !== 1'b1) begin errors++; $display("FAIL dma_ack: got %0b exp 1", bus.dma_ack); end
    exp_v = exp_q.pop_front();
    checks++; if (bus.dma_rdata !== exp_v) begin errors++; $display("FAIL dma_rdata: got %0h exp %0h", bus.dma_rdata, exp_v); end
    checks++; if (bus.dma_err !== 1'b0) begin errors++; $display("FAIL dma_err_aligned: got %0b exp 0", bus.dma_err); end
    next_cycle();
    settle();
    checks++; if (bus.dma_ack !== 1'b0) begin errors++; $display("FAIL dma_ack_pulse: got %0b exp 0", bus.dma_ack); end
    checks++; if (bus.dma_rdata !== 32'h6C) begin errors++; $display("FAIL dma_rdata_hold: got %0h exp 6c", bus.dma_rdata); end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic exp_dma;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b0; bus.dma_addr = 32'h0;
    for (int k = 0; k < 15; k++) begin
      settle();
      exp_dma = (k % 5 == 4);
      checks++; if (bus.cpu_stall !== exp_dma) begin errors++; $display("FAIL starve_grant_%0d: got stall=%0b exp %0b", k, bus.cpu_stall, exp_dma); end
      if (bus.dma_ack) begin
        exp_v = exp_q.pop_front();
        checks++; if (bus.dma_rdata !== exp_v) begin errors++; $display("FAIL starve_dma_rdata_%0d: got %0h exp %0h", k, bus.dma_rdata, exp_v); end
      end
      if (exp_dma) exp_q.push_back(32'h6C);
      else begin
        checks++; if (bus.cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL starve_cpu_rdata_%0d: got %0h exp 12345678", k, bus.cpu_rdata); end
      end
      next_cycle();
    end
    bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
    settle();
    checks++; if (bus.dma_ack !== 1'b1) begin errors++; $display("FAIL starve_last_ack: got %0b exp 1", bus.dma_ack); end
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++; if (bus.dma_rdata !== exp_v) begin errors++; $display("FAIL starve_last_rdata: got %0h exp %0h", bus.dma_rdata, exp_v); end
    end
    next_cycle();
  endtask

  task automatic test_burst();
    int b;
    logic exp_dma;
    for (int i = 0; i < 10; i++) cpu_write(32'h20 + 32'(i * 4), 32'hA000_0000 + 32'(i));
    b = 0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b1; bus.dma_addr = 32'h20;
    for (int k = 0; k < 19; k++) begin
      settle();
      exp_dma = (k >= 4 && k < 12) || (k >= 16 && k < 18);
      checks++; if (bus.cpu_stall !== exp_dma) begin errors++; $display("FAIL burst_grant_%0d: got stall=%0b exp %0b", k, bus.cpu_stall, exp_dma); end
      if (k == 12) begin
        checks++; if (bus.dbg_burst_cnt !== 4'd8) begin errors++; $display("FAIL burst_cnt_limit: got %0d exp 8", bus.dbg_burst_cnt); end
      end
      if (bus.dma_ack) begin
        if (exp_q.size() == 0) begin
          errors++; checks++; $display("FAIL burst_unexpected_ack_%0d: got ack exp none", k);
        end else begin
          exp_v = exp_q.pop_front();
          checks++; if (bus.dma_rdata !== exp_v) begin errors++; $display("FAIL burst_rdata_%0d: got %0h exp %0h", k, bus.dma_rdata, exp_v); end
        end
      end
      if (exp_dma) exp_q.push_back(32'hA000_0000 + 32'(b));
      next_cycle();
      if (bus.dma_ack) b++;
      bus.dma_req  = (b < 10);
      bus.dma_addr = 32'h20 + 32'(b * 4);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL burst_queue_empty: got %0d pending exp 0", exp_q.size()); end
    exp_q.delete();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_misaligned();
    int w0;
    w0 = wr_cnt;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h6; bus.dma_wdata = 32'hDEAD_BEEF;
    settle();
    checks++; if (bus.mem_write !== 1'b0) begin errors++; $display("FAIL misal_mem_write: got %0b exp 0", bus.mem_write); end
    next_cycle();
    bus.dma_req = 1'b0;
    settle();
    checks++; if (bus.dma_ack !== 1'b1 || bus.dma_err !== 1'b1) begin errors++; $display("FAIL misal_ack_err: got %0b/%0b exp 1/1", bus.dma_ack, bus.dma_err); end
    next_cycle();
    settle();
    checks++; if (bus.dma_err !== 1'b0) begin errors++; $display("FAIL misal_err_pulse: got %0b exp 0", bus.dma_err); end
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL misal_no_write: got %0d writes exp %0d", wr_cnt, w0); end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    int b;
    int w0;
    logic found;
    b = 0;
    found = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_lock = 1'b1; bus.dma_addr = 32'h20;
    for (int k = 0; k < 20 && !found; k++) begin
      settle();
      if (bus.dbg_burst_cnt == 4'd3) found = 1'b1;
      else begin
        next_cycle();
        if (bus.dma_ack) b++;
        bus.dma_req  = (b < 10);
        bus.dma_addr = 32'h20 + 32'(b * 4);
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach_cnt3: got burst_cnt=%0d exp 3", bus.dbg_burst_cnt); end
    reset = 1'b0;
    bus.dma_we = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    #1;
    checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_addr !== 32'h0) begin errors++; $display("FAIL midrst_mem: got rd=%0b wr=%0b addr=%0h exp 0/0/0", bus.mem_read, bus.mem_write, bus.mem_addr); end
    checks++; if (bus.dma_ack !== 1'b0 || bus.dma_rdata !== 32'h0) begin errors++; $display("FAIL midrst_dma: got ack=%0b rdata=%0h exp 0/0", bus.dma_ack, bus.dma_rdata); end
    checks++; if (bus.dbg_burst_cnt !== 4'd0 || bus.dbg_state !== IDLE) begin errors++; $display("FAIL midrst_state: got cnt=%0d st=%0d exp 0/0", bus.dbg_burst_cnt, bus.dbg_state); end
    checks++; if (bus.cpu_stall !== 1'b1) begin errors++; $display("FAIL midrst_cpu_stall: got %0b exp 1", bus.cpu_stall); end
    w0 = wr_cnt;
    next_cycle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.dma_we = 1'b0; bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_addr = 32'h20;
    reset = 1'b1;
    exp_q.push_back(32'hA000_0000);
    settle();
    checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL midrst_no_write: got %0d writes exp %0d", wr_cnt, w0); end
    checks++; if (bus.mem_read !== 1'b1 || bus.dbg_burst_cnt !== 4'd0) begin errors++; $display("FAIL postrst_grant: got rd=%0b cnt=%0d exp 1/0", bus.mem_read, bus.dbg_burst_cnt); end
    next_cycle();
    bus.dma_req = 1'b0;
    settle();
    checks++; if (bus.dma_ack !== 1'b1 || bus.dbg_burst_cnt !== 4'd1) begin errors++; $display("FAIL postrst_ack: got ack=%0b cnt=%0d exp 1/1", bus.dma_ack, bus.dbg_burst_cnt); end
    exp_v = exp_q.pop_front();
    checks++; if (bus.dma_rdata !== exp_v) begin errors++; $display("FAIL postrst_rdata: got %0h exp %0h", bus.dma_rdata, exp_v); end
    idle_inputs();
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_dma_only();
    test_starvation();
    test_burst();
    test_misaligned();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
